// File: rtl/sprite_compositor.sv
// N-layer sprite compositor: per-frame shadowed attributes, priority/colour-key merge, collision mask.
// Latency pixel_x/y -> rgb is ROM_LAT+2 cycles, fully pipelined with no stalls and no backpressure.
module sprite_compositor #(
  parameter int NUM_SPR     = 4,
  parameter int COORD_W     = 10,
  parameter int ADDR_W      = 18,
  parameter int COLOR_W     = 12,
  parameter logic [COLOR_W-1:0] KEY_COLOR = 12'h0F0,
  parameter int SCALE_SHIFT = 1,
  parameter int BG_W        = 320,
  parameter int ROM_LAT     = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [9:0]                  pixel_x,
  input  logic [9:0]                  pixel_y,
  input  logic                        video_on,
  input  logic                        frame_start,
  input  logic [NUM_SPR-1:0]          spr_en,
  input  logic [NUM_SPR*COORD_W-1:0]  spr_x,
  input  logic [NUM_SPR*COORD_W-1:0]  spr_y,
  input  logic [NUM_SPR*8-1:0]        spr_w,
  input  logic [NUM_SPR*8-1:0]        spr_h,
  input  logic [NUM_SPR*ADDR_W-1:0]   spr_base,
  input  logic [NUM_SPR-1:0]          spr_flip,
  output logic [NUM_SPR*ADDR_W-1:0]   rom_addr,
  input  logic [NUM_SPR*COLOR_W-1:0]  rom_data,
  output logic [ADDR_W-1:0]           bg_addr,
  input  logic [COLOR_W-1:0]          bg_data,
  output logic [COLOR_W-1:0]          rgb,
  output logic [NUM_SPR-1:0]          collide
);

  logic [NUM_SPR-1:0]         sh_en, sh_flip;
  logic [NUM_SPR*COORD_W-1:0] sh_x, sh_y;
  logic [NUM_SPR*8-1:0]       sh_w, sh_h;
  logic [NUM_SPR*ADDR_W-1:0]  sh_base;

  logic [COORD_W-1:0]         sx, sy;
  logic [NUM_SPR-1:0]         hit_c;
  logic [NUM_SPR*ADDR_W-1:0]  addr_c;
  logic [ADDR_W-1:0]          bg_c;

  logic [NUM_SPR-1:0]               hit_s1;
  logic                             von_s1;
  logic [ROM_LAT-1:0][NUM_SPR-1:0]  hit_dly;
  logic [ROM_LAT-1:0]               von_dly;
  logic [NUM_SPR-1:0]               hit_a, opaque, coll_c, acc;
  logic                             von_a, multi;
  logic [COLOR_W-1:0]               pix_c;

  assign sx = COORD_W'(pixel_x >> SCALE_SHIFT);
  assign sy = COORD_W'(pixel_y >> SCALE_SHIFT);
  assign bg_c = ADDR_W'(sy) * ADDR_W'(BG_W) + ADDR_W'(sx);

  assign hit_a = hit_dly[ROM_LAT-1];
  assign von_a = von_dly[ROM_LAT-1];

  for (genvar i = 0; i < NUM_SPR; i++) begin : g_spr
    logic [COORD_W:0]   x0, y0, x1, y1;
    logic [COORD_W-1:0] dx, dy;
    logic [7:0]         w, h;
    logic [ADDR_W-1:0]  base, col, row_off;

    assign w    = sh_w[i*8 +: 8];
    assign h    = sh_h[i*8 +: 8];
    assign base = sh_base[i*ADDR_W +: ADDR_W];
    // One extra bit keeps x+w / y+h from wrapping past the buffer edge.
    assign x0 = {1'b0, sh_x[i*COORD_W +: COORD_W]};
    assign y0 = {1'b0, sh_y[i*COORD_W +: COORD_W]};
    assign x1 = x0 + (COORD_W+1)'(w);
    assign y1 = y0 + (COORD_W+1)'(h);

    assign hit_c[i] = sh_en[i] && ({1'b0, sx} >= x0) && ({1'b0, sx} < x1)
                               && ({1'b0, sy} >= y0) && ({1'b0, sy} < y1);

    assign dx      = sx - sh_x[i*COORD_W +: COORD_W];
    assign dy      = sy - sh_y[i*COORD_W +: COORD_W];
    assign row_off = ADDR_W'(dy) * ADDR_W'(w);
    assign col     = sh_flip[i] ? (ADDR_W'(w) - ADDR_W'(1) - ADDR_W'(dx)) : ADDR_W'(dx);
    assign addr_c[i*ADDR_W +: ADDR_W] = hit_c[i] ? (base + row_off + col) : base;

    assign opaque[i] = hit_a[i] && (rom_data[i*COLOR_W +: COLOR_W] != KEY_COLOR);
  end

  // Lowest index wins: walk from the back so the last assignment is the highest priority.
  always_comb begin
    pix_c = bg_data;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (opaque[i]) pix_c = rom_data[i*COLOR_W +: COLOR_W];
    end
    if (!von_a) pix_c = '0;
  end

  assign multi  = |(opaque & (opaque - NUM_SPR'(1)));
  assign coll_c = (von_a && multi) ? opaque : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_en    <= '0;
      sh_flip  <= '0;
      sh_x     <= '0;
      sh_y     <= '0;
      sh_w     <= '0;
      sh_h     <= '0;
      sh_base  <= '0;
      rom_addr <= '0;
      bg_addr  <= '0;
      hit_s1   <= '0;
      von_s1   <= 1'b0;
      hit_dly  <= '0;
      von_dly  <= '0;
      rgb      <= '0;
      collide  <= '0;
      acc      <= '0;
    end else begin
      if (frame_start) begin
        sh_en   <= spr_en;
        sh_flip <= spr_flip;
        sh_x    <= spr_x;
        sh_y    <= spr_y;
        sh_w    <= spr_w;
        sh_h    <= spr_h;
        sh_base <= spr_base;
        collide <= acc;
        acc     <= coll_c;
      end else begin
        acc     <= acc | coll_c;
      end
      rom_addr   <= addr_c;
      bg_addr    <= bg_c;
      hit_s1     <= hit_c;
      von_s1     <= video_on;
      hit_dly[0] <= hit_s1;
      von_dly[0] <= von_s1;
      for (int k = 1; k < ROM_LAT; k++) begin
        hit_dly[k] <= hit_dly[k-1];
        von_dly[k] <= von_dly[k-1];
      end
      rgb <= pix_c;
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// Scoreboard bench for sprite_compositor: ROM_LAT=1 main instance plus a ROM_LAT=3 instance for latency.
// Stimulus pushes expected values tagged with a due cycle; a negedge monitor pops and compares.
module tb_sprite_compositor;

  localparam int K_RGB = 0, K_COL = 1, K_RA = 2, K_BG = 3, K_RGB3 = 4, K_COL3 = 5;

  typedef struct {
    int          due;
    int          kind;
    int          idx;
    logic [31:0] exp;
    string       name;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  pixel_x, pixel_y;
  logic        video_on, frame_start;
  logic [3:0]  spr_en, spr_flip;
  logic [39:0] spr_x, spr_y;
  logic [31:0] spr_w, spr_h;
  logic [71:0] spr_base;
  logic [71:0] rom_addr, rom_addr3;
  logic [47:0] rom_data;
  logic [17:0] bg_addr, bg_addr3;
  logic [11:0] bg_data, rgb, rgb3;
  logic [3:0]  collide, collide3;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  sb_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sprite_compositor dut (
    .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .frame_start(frame_start), .spr_en(spr_en),
    .spr_x(spr_x), .spr_y(spr_y), .spr_w(spr_w), .spr_h(spr_h),
    .spr_base(spr_base), .spr_flip(spr_flip), .rom_addr(rom_addr),
    .rom_data(rom_data), .bg_addr(bg_addr), .bg_data(bg_data),
    .rgb(rgb), .collide(collide)
  );

  sprite_compositor #(.ROM_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .frame_start(frame_start), .spr_en(spr_en),
    .spr_x(spr_x), .spr_y(spr_y), .spr_w(spr_w), .spr_h(spr_h),
    .spr_base(spr_base), .spr_flip(spr_flip), .rom_addr(rom_addr3),
    .rom_data(rom_data), .bg_addr(bg_addr3), .bg_data(bg_data),
    .rgb(rgb3), .collide(collide3)
  );

  function automatic logic [31:0] actual(input int kind, input int idx);
    case (kind)
      K_RGB:   return {20'b0, rgb};
      K_COL:   return {28'b0, collide};
      K_RA:    return {14'b0, rom_addr[idx*18 +: 18]};
      K_BG:    return {14'b0, bg_addr};
      K_RGB3:  return {20'b0, rgb3};
      default: return {28'b0, collide3};
    endcase
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        logic [31:0] got;
        got = actual(sb[i].kind, sb[i].idx);
        checks++;
        if (got !== sb[i].exp) begin
          errors++;
          $display("FAIL %s (cycle %0d): got %0h expected %0h", sb[i].name, cyc, got, sb[i].exp);
        end
        sb.delete(i);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int idx, input int dly, input logic [31:0] exp, input string name);
    sb_t e;
    e.due = cyc + dly; e.kind = kind; e.idx = idx; e.exp = exp; e.name = name;
    sb.push_back(e);
  endtask

  task automatic set_spr(input int i, input logic en, input int x, input int y, input int w,
                         input int h, input int base, input logic flip);
    spr_en[i]             = en;
    spr_x[i*10 +: 10]     = 10'(x);
    spr_y[i*10 +: 10]     = 10'(y);
    spr_w[i*8 +: 8]       = 8'(w);
    spr_h[i*8 +: 8]       = 8'(h);
    spr_base[i*18 +: 18]  = 18'(base);
    spr_flip[i]           = flip;
  endtask

  task automatic pix(input int x, input int y);
    pixel_x = 10'(x);
    pixel_y = 10'(y);
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; video_on = 1'b1; frame_start = 1'b1;
    pix(5, 7);
    spr_en = 4'hF; spr_flip = 4'hF;
    spr_x = {4{10'd3}}; spr_y = {4{10'd3}};
    spr_w = {4{8'd5}};  spr_h = {4{8'd5}};
    spr_base = {4{18'd9}};
    rom_data = {4{12'hABC}}; bg_data = 12'h321;

    // Reset held three cycles with busy inputs.
    step(3);
    push(K_RGB, 0, 0, 0, "reset_rgb");
    push(K_COL, 0, 0, 0, "reset_collide");
    push(K_RA, 0, 0, 0, "reset_rom_addr0");
    push(K_RA, 3, 0, 0, "reset_rom_addr3");
    push(K_BG, 0, 0, 0, "reset_bg_addr");
    push(K_RGB3, 0, 0, 0, "reset_rgb_lat3");
    push(K_COL3, 0, 0, 0, "reset_collide_lat3");

    // Release: shadows must still be clear (reset beat frame_start), background shows.
    reset = 1'b0; frame_start = 1'b0;
    pix(100, 50); bg_data = 12'h123;
    push(K_RGB, 0, 3, 12'h123, "bg_only_rgb");
    push(K_BG, 0, 1, 8050, "bg_addr_100_50");
    push(K_RA, 0, 1, 0, "shadow_cleared_base");
    step(4);

    spr_en = 4'b0000;
    set_spr(0, 1'b1, 10, 20, 41, 42, 1722, 1'b0);
    pulse_fs();
    pix(24, 44);   push(K_RA, 0, 1, 1806, "addr_s0");          step(2);
    pix(0, 0);     push(K_RA, 0, 1, 1722, "addr_s0_miss");     step(2);
    pix(100, 44);  push(K_RA, 0, 1, 1844, "addr_s0_lastcol");  step(2);
    pix(102, 44);  push(K_RA, 0, 1, 1722, "addr_s0_pastcol");  step(2);
    pix(24, 122);  push(K_RA, 0, 1, 3405, "addr_s0_lastrow");  step(2);
    pix(24, 124);  push(K_RA, 0, 1, 1722, "addr_s0_pastrow");  step(2);

    spr_flip[0] = 1'b1;
    pulse_fs();
    pix(24, 44);   push(K_RA, 0, 1, 1842, "addr_s0_flip");     step(2);

    // Overlap of sprites 0 and 2.
    set_spr(0, 1'b1, 10, 20, 41, 42, 1722, 1'b0);
    set_spr(2, 1'b1, 10, 20, 41, 42, 5000, 1'b0);
    rom_data = {12'h555, 12'h00F, 12'h555, 12'hF00};
    frame_start = 1'b1;
    push(K_COL, 0, 1, 0, "collide_none_yet");
    step(1);
    frame_start = 1'b0;
    push(K_RGB, 0, 3, 12'hF00, "prio_s0_over_s2");
    push(K_RA, 2, 1, 5084, "addr_s2");
    step(4);
    rom_data[11:0] = 12'h0F0;
    push(K_RGB, 0, 2, 12'h00F, "s0_keyed_shows_s2");
    step(3);
    frame_start = 1'b1;
    push(K_COL, 0, 1, 4'b0101, "collide_0101");
    step(1);
    frame_start = 1'b0;
    step(3);
    frame_start = 1'b1;
    push(K_COL, 0, 1, 0, "collide_cleared");
    step(1);
    frame_start = 1'b0;

    // Mid-frame attribute change stays hidden until frame_start.
    spr_x[9:0] = 10'd11;
    push(K_RA, 0, 1, 1806, "x_change_ignored");
    step(3);
    pulse_fs();
    push(K_RA, 0, 1, 1805, "x_change_applied");
    step(2);

    // Right-edge wrap and zero-width sprites never hit.
    set_spr(1, 1'b1, 1020, 0, 10, 255, 7777, 1'b0);
    set_spr(3, 1'b1, 0, 0, 0, 10, 999, 1'b0);
    pulse_fs();
    pix(4, 10);
    push(K_RA, 1, 1, 7777, "no_wrap_addr1");
    push(K_RA, 3, 1, 999, "w0_addr3_a");
    push(K_BG, 0, 1, 1602, "bg_addr_4_10");
    push(K_RGB, 0, 3, 12'h123, "no_wrap_rgb");
    step(4);
    pix(0, 0);
    push(K_RA, 3, 1, 999, "w0_addr3_b");
    push(K_RGB, 0, 3, 12'h123, "w0_rgb");
    step(4);

    // video_on gating and exact latency for both ROM latencies.
    rom_data[11:0] = 12'hF00;
    pix(24, 44);
    video_on = 1'b0;
    push(K_RGB, 0, 3, 0, "blank_rgb");
    push(K_RGB3, 0, 5, 0, "blank_rgb_lat3");
    step(6);
    video_on = 1'b1;
    push(K_RGB, 0, 2, 0, "lat1_early");
    push(K_RGB, 0, 3, 12'hF00, "lat1_exact");
    push(K_RGB3, 0, 4, 0, "lat3_early");
    push(K_RGB3, 0, 5, 12'hF00, "lat3_exact");
    step(6);
    frame_start = 1'b1;
    push(K_COL, 0, 1, 4'b0101, "collide_again");
    push(K_COL3, 0, 1, 4'b0101, "collide_again_lat3");
    step(1);
    frame_start = 1'b0;
    step(3);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
